// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - shared encodings and types for the data SRAM responder
package data_sram_responder_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int DS_REQ_BUS_WID = 1 + 2 + 4 + 32 + 32;
  localparam int DS_DEF_LATENCY = 2;
  localparam int DS_DEF_QDEPTH  = 4;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ds_req_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] data;
    logic [3:0]  cnt;
  } ds_entry_t;

endpackage

// File: rtl/data_sram_responder_queue.sv
// rtl/data_sram_responder_queue.sv - in-order response FIFO with per-entry latency countdown
module ds_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int QDEPTH  = DS_DEF_QDEPTH,
  parameter int LATENCY = DS_DEF_LATENCY,
  localparam int PW     = $clog2(QDEPTH)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        head_ready,
  output logic        head_wr,
  output logic [31:0] head_data,
  output logic [PW:0] count
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  ds_entry_t         ent [QDEPTH];
  logic [QDEPTH-1:0] vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  // Push only happens below full, so the write slot never holds a live entry.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (push && (PW'(i) == wr_ptr)) begin
          ent[i] <= '{wr: push_wr, data: push_data, cnt: CNT_INIT};
          vld[i] <= 1'b1;
        end else begin
          if (vld[i] && (ent[i].cnt != 4'd0)) begin
            ent[i].cnt <= ent[i].cnt - 4'd1;
          end
          if (pop && (PW'(i) == rd_ptr)) begin
            vld[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign head_ready = vld[rd_ptr] && (ent[rd_ptr].cnt == 4'd0);
  assign head_wr    = ent[rd_ptr].wr;
  assign head_data  = ent[rd_ptr].data;

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: word array, request accept and response gating
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = DS_DEF_LATENCY,
  parameter int QDEPTH     = DS_DEF_QDEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        addr_stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = $clog2(QDEPTH);

  logic [31:0]               mem [2**ADDR_WIDTH];
  logic [DS_REQ_BUS_WID-1:0] req_bus;
  ds_req_t                   rq;
  logic [ADDR_WIDTH-1:0]     idx;
  logic [PW:0]               count;
  logic                      head_ready;
  logic                      head_wr;
  logic [31:0]               head_data;
  logic                      unused_bits;

  assign req_bus = {wr, size, wstrb, addr, wdata};
  assign rq      = ds_req_t'(req_bus);
  assign idx     = rq.addr[ADDR_WIDTH+1:2];

  // Size is informational and upper address bits alias; wstrb alone drives writes.
  assign unused_bits = ^{rq.addr[31:ADDR_WIDTH+2], rq.addr[1:0],
                         rq.size == SZ_BYTE, rq.size == SZ_HALF, rq.size == SZ_WORD};

  // Full is judged on registered count only: no accept-on-pop bypass.
  assign addr_ok = req && !addr_stall && (count < (PW+1)'(QDEPTH)) && rstn;

  always_ff @(posedge clk) begin
    if (addr_ok && rq.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (rq.wstrb[i]) begin
          mem[idx][8*i +: 8] <= rq.wdata[8*i +: 8];
        end
      end
    end
  end

  ds_resp_queue #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk        (clk),
    .rstn       (rstn),
    .push       (addr_ok),
    .push_wr    (rq.wr),
    .push_data  (mem[idx]),
    .pop        (data_ok),
    .head_ready (head_ready),
    .head_wr    (head_wr),
    .head_data  (head_data),
    .count      (count)
  );

  assign data_ok = head_ready && rstn;
  assign rdata   = (data_ok && !head_wr) ? head_data : 32'd0;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized bench for data_sram_responder against a deadline-based model
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_stall;
  logic [2:0]  aok;
  logic [2:0]  dok;
  logic [31:0] rd [3];

  int   tests = 0;
  int   fails = 0;
  event chk_ev;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Three configurations: nominal, deep latency that fills the queue, and single-cycle latency.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AW = (g == 0) ? 12 : ((g == 1) ? 6 : 4);
    localparam int L  = (g == 0) ? 2  : ((g == 1) ? 8 : 1);
    localparam int Q  = (g == 0) ? 4  : ((g == 1) ? 4 : 2);

    typedef struct {
      bit          wr;
      bit          known;
      logic [31:0] data;
      int          ready;
    } rsp_t;

    rsp_t        q [$];
    logic [31:0] mem [int];
    bit          kn [int];
    int          cyc = 0;

    data_sram_responder #(
      .ADDR_WIDTH (AW),
      .LATENCY    (L),
      .QDEPTH     (Q)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .req        (req),
      .wr         (wr),
      .size       (size),
      .wstrb      (wstrb),
      .addr       (addr),
      .wdata      (wdata),
      .addr_stall (addr_stall),
      .addr_ok    (aok[g]),
      .data_ok    (dok[g]),
      .rdata      (rd[g])
    );

    always @(chk_ev) begin
      bit          e_aok;
      bit          e_dok;
      bit          rd_known;
      logic [31:0] e_rd;
      int          idx;
      rsp_t        e;

      e_aok    = rstn && req && !addr_stall && (q.size() < Q);
      e_dok    = rstn && (q.size() != 0) && (q[0].ready <= cyc);
      e_rd     = 32'd0;
      rd_known = 1'b1;
      if (e_dok && !q[0].wr) begin
        e_rd     = q[0].data;
        rd_known = q[0].known;
      end
      check($sformatf("i%0d_addr_ok c%0d", g, cyc), 32'(aok[g]), 32'(e_aok));
      check($sformatf("i%0d_data_ok c%0d", g, cyc), 32'(dok[g]), 32'(e_dok));
      if (rd_known) begin
        check($sformatf("i%0d_rdata c%0d", g, cyc), rd[g], e_rd);
      end

      if (!rstn) begin
        q.delete();
      end else begin
        if (e_dok) begin
          void'(q.pop_front());
        end
        if (e_aok) begin
          idx = int'(addr[AW+1:2]);
          if (!mem.exists(idx)) begin
            mem[idx] = 32'd0;
            kn[idx]  = 1'b0;
          end
          e.ready = cyc + L;
          if (wr) begin
            for (int i = 0; i < 4; i++) begin
              if (wstrb[i]) mem[idx][8*i +: 8] = wdata[8*i +: 8];
            end
            if (wstrb == 4'hF) kn[idx] = 1'b1;
            e.wr    = 1'b1;
            e.known = 1'b1;
            e.data  = 32'd0;
          end else begin
            e.wr    = 1'b0;
            e.known = kn[idx];
            e.data  = mem[idx];
          end
          q.push_back(e);
        end
      end
      cyc++;
    end
  end

  function automatic logic [31:0] mk_addr(input int i);
    logic [31:0] a;
    a       = $urandom;
    a[13:6] = 8'd0;
    a[5:2]  = 4'(i);
    return a;
  endfunction

  task automatic step(input bit r, input bit w, input logic [3:0] st, input logic [31:0] a,
                      input logic [31:0] d, input bit stl, input bit rn);
    @(negedge clk);
    req        = r;
    wr         = w;
    wstrb      = st;
    addr       = a;
    wdata      = d;
    addr_stall = stl;
    rstn       = rn;
    size       = 2'($urandom_range(0, 2));
    #1 ->chk_ev;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  st;
    rstn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; wstrb = 4'h0;
    addr = 32'd0; wdata = 32'd0; addr_stall = 1'b0;

    repeat (3) step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      repeat (12) step(1'b1, 1'b1, 4'hF, mk_addr(i), d, 1'b0, 1'b1);
    end
    idle(20);

    step(1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 32'h100, $urandom, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b0001, 32'h100, 32'h000000AA, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b1100, 32'h100, 32'h55550000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 32'h100, 32'd0, 1'b0, 1'b1);
    idle(20);

    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'h0, mk_addr(i), 32'd0, 1'b0, 1'b1);
    idle(20);

    repeat (3) step(1'b1, 1'b0, 4'h0, mk_addr(3), 32'd0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 4'h0, mk_addr(4), 32'd0, 1'b0, 1'b1);
    idle(20);

    step(1'b1, 1'b1, 4'hF, mk_addr(5), 32'hCAFEF00D, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, mk_addr(i + 8), 32'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 4'h0, mk_addr(5), 32'd0, 1'b0, 1'b1);
    idle(20);

    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      step(1'b1, 1'b1, 4'hF, mk_addr(7), d, 1'b0, 1'b1);
      step(1'b1, 1'b0, 4'h0, mk_addr(7), 32'd0, 1'b0, 1'b1);
    end
    idle(20);

    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), st, mk_addr($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 199) != 0);
    end
    idle(30);

    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the core's data SRAM-like interface: accepts load/store requests, applies byte-strobed writes, returns read data in order after a fixed latency.
- The Memory stage consumes its rdata/data_ok.
- Used as the on-chip data RAM in simulation and FPGA builds, and as a latency/back-pressure model for verifying the load/store pipeline.

Parameters:
- ADDR_WIDTH, 12, word-index bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, minimum cycles from acceptance to data_ok; legal range 1..15.
- QDEPTH, 4, maximum outstanding accepted-but-unanswered requests; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- req  in  1  request valid
- wr  in  1  1 = store, 0 = load
- size  in  2  0 = byte, 1 = half, 2 = word
- wstrb  in  4  byte write enables; used only when wr=1
- addr  in  32  byte address
- wdata  in  32  store data
- addr_stall  in  1  bench/system back-pressure; forces addr_ok low
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  response valid this cycle
- rdata  out  32  full aligned word for loads; 0 for stores and when data_ok=0

Behaviour:
- Reset: rstn is synchronous and active-low; clock is clk.
- Reset effects: queue emptied (count=0, pointers=0), data_ok=0, rdata=0, addr_ok=0 during the reset cycle. Array contents are not reset.
- Reset mid-operation: all outstanding responses are discarded and no data_ok is issued for them. Stores already accepted remain committed.
- addr_ok = req && !addr_stall && (count < QDEPTH) && rstn. It is combinational from registered state plus req and addr_stall.
- Full rule: full is evaluated on the registered count only. There is no bypass: at count==QDEPTH, addr_ok stays low even in a cycle where a pop occurs.
- Acceptance (req && addr_ok at edge t):
  - index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored, so addresses alias.
  - Store: for each set wstrb[i], mem[index][8i+7:8i] <= wdata[8i+7:8i]. The write commits at edge t. size is informational only.
  - Load: the whole word mem[index] is sampled at acceptance, before any write accepted in the same cycle (only one request per cycle exists). The value is stored in the queue entry.
  - Entry fields: {wr, data[31:0], cnt[3:0]}, with cnt initialised to LATENCY-1.
- Every cycle, each valid entry with cnt!=0 decrements cnt.
- Response:
  - data_ok = head valid && head.cnt==0.
  - rdata = head.wr ? 0 : head.data, gated to 0 when data_ok=0.
  - The head pops at the edge where data_ok=1.
  - At most one response per cycle; responses are strictly in acceptance order.
- Latency: with no queueing, a request accepted at edge t gives data_ok in the cycle after edge t+LATENCY-1. For LATENCY=1 this is the cycle immediately after acceptance.
- Queueing: a request queued behind others responds at the later of its own countdown expiry and the cycle after the previous response.
- Ordering: because stores commit and loads sample at acceptance, a load accepted after a store to the same word returns the stored bytes. A load accepted before a store returns the old data, even if it is answered later.
- Simultaneous push and pop: count is unchanged and the pointers advance independently.
- Pointer wrap: at QDEPTH with no special case (log2(QDEPTH)-bit pointers; count is log2(QDEPTH)+1 bits).
- Illegal wstrb/size combinations are not checked; wstrb alone governs the write.
- The load extension/alignment belongs to the core, not this block.

Decomposition:
- Shared package/header (Defines.vh additions):
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - DS_REQ_BUS_Wid
  - default LATENCY/QDEPTH constants
- One sub-module: ds_resp_queue.
  - Contains the QDEPTH-entry FIFO with per-entry countdowns, head-ready output, and push/pop/count logic.
  - The top level holds the array, accept logic and output gating.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF to 0x100, wstrb=4'hF (accepted t0), then load 0x100 (accepted t1) -> data_ok at cycles t0+2 and t1+2; load rdata=0xDEADBEEF; store rdata=0.
- Byte/half strobes: after the word above, store wdata=0x0000_00AA wstrb=4'b0001, then wdata=0x5555_0000 wstrb=4'b1100 to 0x100 -> load returns 0x5555BEAA.
- Queue full: LATENCY=8, QDEPTH=4, req held high with 6 back-to-back loads -> addr_ok high for 4 cycles, then low until the first data_ok (no same-cycle accept); 4 responses on consecutive cycles, in order.
- Back-pressure: addr_stall=1 for 3 cycles with req=1 -> addr_ok=0 and no queue change. After release: accepted next cycle, data_ok LATENCY later.
- Reset mid-flight: 3 loads outstanding, rstn=0 for 1 cycle -> no data_ok afterwards, count=0, addr_ok resumes the cycle after reset release. A store accepted before reset reads back correctly.
- LATENCY=1 with alternating store/load to the same word every cycle -> each load returns the preceding store data, data_ok every cycle, rdata alternating 0 and data.
